boot_sequencer: RTL and testbench
=================================

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 Parameter LOAD_BYTES, default 65536; number of program bytes that completes an SD or UART load (1..65536).
REQ-002 Parameter SD_TIMEOUT, default 10_000_000; maximum idle clock cycles between SD bytes before the SD load is declared failed.
REQ-003 Port clk  in  1  single system clock; all logic is clocked on its rising edge.
REQ-004 Port rst  in  1  reset; synchronous, active-high.
REQ-005 Port mem_calib_done  in  1  LPDDR calibration complete (level).
REQ-006 Port mem_error  in  1  LPDDR bit error (level, may assert at any time).
REQ-007 Port clear_start  out  1  one-cycle pulse that starts video-memory zeroing.
REQ-008 Port clear_done  in  1  video memory zeroed (level).
REQ-009 Port sdcard_present  in  1  card-detect (level, sampled once).
REQ-010 Port sdcard_start  out  1  one-cycle pulse that starts the SD reader.
REQ-011 Port sdcard_byte_valid  in  1  one SD byte written to RAM this cycle.
REQ-012 Port sdcard_fail  in  1  SD reader error pulse.
REQ-013 Port uart_byte_valid  in  1  one UART byte written to RAM this cycle.
REQ-014 Port status outputs, all registered: clear_screen_done, sdcard_read_started, sdcard_read_done, sdcard_read_error, uart_load_started, uart_load_done, boot_done (1 bit each); sdcard_progress, uart_progress (8 bits each); their meanings match the display-status inputs of the same names.
REQ-015 Port cpu_run  out  1  processor may execute; equals boot_done.

Function
REQ-016 FSM states: WAIT_CALIB, CLEAR, SD_LOAD, UART_LOAD, RUN, HALT.
REQ-017 WAIT_CALIB -> CLEAR when mem_calib_done=1; clear_start pulses in the first CLEAR cycle only.
REQ-018 CLEAR -> SD_LOAD when clear_done=1 and sdcard_present=1; -> UART_LOAD when clear_done=1 and sdcard_present=0; clear_screen_done is set on that transition.
REQ-019 On entering SD_LOAD, sdcard_start pulses for one cycle and sdcard_read_started is set.
REQ-020 17-bit byte counter: cleared on entry to SD_LOAD and to UART_LOAD; incremented by 1 per byte_valid of the active source; bytes from the inactive source are ignored.
REQ-021 Progress = counter[15:8] of the active source's load; saturates at 8'hFF once counter >= 65536; held after the load completes.
REQ-022 SD_LOAD -> RUN in the cycle after counter reaches LOAD_BYTES; sdcard_read_done and boot_done are set.
REQ-023 SD_LOAD -> HALT on sdcard_fail or when the idle counter reaches SD_TIMEOUT; sdcard_read_error is set; boot_done stays 0.
REQ-024 Idle counter clears on every sdcard_byte_valid and on SD_LOAD entry.
REQ-025 If sdcard_fail and sdcard_byte_valid coincide, the error wins and the byte is not counted.
REQ-026 On entering UART_LOAD, uart_load_started is set; UART_LOAD has no timeout and -> RUN when counter reaches LOAD_BYTES, setting uart_load_done and boot_done.
REQ-027 mem_error=1 in any state except RUN -> HALT; in RUN it is ignored by the FSM.
REQ-028 All status flags are sticky until rst; HALT and RUN are exited only by rst.
REQ-029 Boot-to-run latency after the final byte is exactly 1 cycle.

Reset
REQ-030 On rst: state=WAIT_CALIB; every output, including the pulses, is 0; counters are 0.
REQ-031 rst asserted mid-load aborts the load with no further start pulse until the sequence re-runs.

Structure
REQ-032 State encodings and the LOAD_BYTES/SD_TIMEOUT defaults live in the shared definitions header.
REQ-033 A single sub-module, load_counter, contains the byte counter, the progress saturation and the idle timer.

Verification
REQ-034 Calib at cycle 10, clear_done 100 cycles later, card present, 65536 SD bytes -> single clear_start and sdcard_start pulses; sdcard_progress=8'h80 after 32768 bytes; boot_done 1 cycle after the last byte.
REQ-035 Card absent, LOAD_BYTES=256, 256 UART bytes -> uart_load_done=1, sdcard_read_started=0, uart_progress=8'h01.
REQ-036 SD load with a stall of SD_TIMEOUT=100 cycles -> sdcard_read_error=1 at idle count 100; boot_done stays 0.
REQ-037 sdcard_fail coincident with byte 5 -> count stays 4; state=HALT.
REQ-038 mem_error pulse during CLEAR -> HALT; the same pulse in RUN -> cpu_run stays 1.
REQ-039 rst in the middle of the SD load -> all outputs 0 on the next cycle; the sequence restarts cleanly.

Source files
------------

// File: rtl/boot_sequencer_pkg.sv
// Shared definitions for the boot sequencer: FSM states, status flag bundle
// and the default load size / SD idle timeout.
package boot_sequencer_pkg;

  localparam int unsigned DEF_LOAD_BYTES = 65536;
  localparam int unsigned DEF_SD_TIMEOUT = 10_000_000;
  localparam int unsigned CNT_W          = 17;
  localparam int unsigned PROG_W         = 8;

  typedef enum logic [2:0] {
    ST_WAIT_CALIB = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_SD_LOAD    = 3'd2,
    ST_UART_LOAD  = 3'd3,
    ST_RUN        = 3'd4,
    ST_HALT       = 3'd5
  } boot_state_e;

  typedef struct packed {
    logic clear_screen_done;
    logic sdcard_read_started;
    logic sdcard_read_done;
    logic sdcard_read_error;
    logic uart_load_started;
    logic uart_load_done;
    logic boot_done;
  } boot_status_t;

endpackage

// File: rtl/boot_sequencer_load_counter.sv
// Byte counter, saturating progress and SD idle timer shared by both load
// sources; only the active source's byte strobe is fed in.
module load_counter
  import boot_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_BYTES = DEF_LOAD_BYTES,
  parameter int unsigned SD_TIMEOUT = DEF_SD_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic              idle_en,
  input  logic              idle_clr,
  output logic [PROG_W-1:0] progress_next,
  output logic              last_byte,
  output logic              idle_hit
);

  localparam int unsigned IDLE_W = $clog2(SD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LOAD_BYTES - 1);
  localparam logic [CNT_W-1:0]  SAT_LIMIT = CNT_W'(65536);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(SD_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SD_TIMEOUT - 1);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  function automatic logic [PROG_W-1:0] sat_progress(input logic [CNT_W-1:0] c);
    if (c >= SAT_LIMIT) return '1;
    return c[CNT_W-2 -: PROG_W];
  endfunction

  always_comb begin
    count_d = count_q;
    idle_d  = idle_q;
    if (clr) begin
      count_d = '0;
      idle_d  = '0;
    end else begin
      if (inc) count_d = count_q + CNT_W'(1);
      if (idle_clr) idle_d = '0;
      else if (idle_en && idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Stage p0 -> state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      idle_q  <= '0;
    end else begin
      count_q <= count_d;
      idle_q  <= idle_d;
    end
  end

  // Both strobes look one count ahead so the FSM reacts on the same edge
  // that records the final byte / final idle cycle.
  assign last_byte     = inc && (count_q == LAST_CNT);
  assign idle_hit      = idle_en && !idle_clr && (idle_q == IDLE_LAST);
  assign progress_next = sat_progress(count_d);

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: waits for LPDDR calibration, clears video memory, loads the
// program from SD card (or UART when no card) and then releases the CPU.
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_BYTES = DEF_LOAD_BYTES,
  parameter int unsigned SD_TIMEOUT = DEF_SD_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_calib_done,
  input  logic       mem_error,
  output logic       clear_start,
  input  logic       clear_done,
  input  logic       sdcard_present,
  output logic       sdcard_start,
  input  logic       sdcard_byte_valid,
  input  logic       sdcard_fail,
  input  logic       uart_byte_valid,
  output logic       clear_screen_done,
  output logic       sdcard_read_started,
  output logic       sdcard_read_done,
  output logic       sdcard_read_error,
  output logic       uart_load_started,
  output logic       uart_load_done,
  output logic       boot_done,
  output logic [7:0] sdcard_progress,
  output logic [7:0] uart_progress,
  output logic       cpu_run
);

  boot_state_e       state_q, state_d;
  boot_status_t      status_q, status_d;
  logic              clear_start_q, clear_start_d;
  logic              sdcard_start_q, sdcard_start_d;
  logic [PROG_W-1:0] sd_prog_q, sd_prog_d;
  logic [PROG_W-1:0] uart_prog_q, uart_prog_d;

  logic              in_sd, in_uart, byte_inc, cnt_clr;
  logic [PROG_W-1:0] progress_next;
  logic              last_byte, idle_hit;

  assign in_sd    = (state_q == ST_SD_LOAD);
  assign in_uart  = (state_q == ST_UART_LOAD);
  // A failing SD byte is dropped; the error path wins.
  assign byte_inc = !mem_error &&
                    ((in_sd && sdcard_byte_valid && !sdcard_fail) ||
                     (in_uart && uart_byte_valid));
  assign cnt_clr  = (state_q == ST_CLEAR) && clear_done && !mem_error;

  load_counter #(
    .LOAD_BYTES (LOAD_BYTES),
    .SD_TIMEOUT (SD_TIMEOUT)
  ) u_load_counter (
    .clk           (clk),
    .rst           (rst),
    .clr           (cnt_clr),
    .inc           (byte_inc),
    .idle_en       (in_sd),
    .idle_clr      (sdcard_byte_valid),
    .progress_next (progress_next),
    .last_byte     (last_byte),
    .idle_hit      (idle_hit)
  );

  always_comb begin
    state_d        = state_q;
    status_d       = status_q;
    clear_start_d  = 1'b0;
    sdcard_start_d = 1'b0;
    unique case (state_q)
      ST_WAIT_CALIB: begin
        if (mem_error) state_d = ST_HALT;
        else if (mem_calib_done) begin
          state_d       = ST_CLEAR;
          clear_start_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (mem_error) state_d = ST_HALT;
        else if (clear_done) begin
          status_d.clear_screen_done = 1'b1;
          if (sdcard_present) begin
            state_d                      = ST_SD_LOAD;
            sdcard_start_d               = 1'b1;
            status_d.sdcard_read_started = 1'b1;
          end else begin
            state_d                    = ST_UART_LOAD;
            status_d.uart_load_started = 1'b1;
          end
        end
      end
      ST_SD_LOAD: begin
        if (mem_error) state_d = ST_HALT;
        else if (sdcard_fail || idle_hit) begin
          state_d                    = ST_HALT;
          status_d.sdcard_read_error = 1'b1;
        end else if (last_byte) begin
          state_d                   = ST_RUN;
          status_d.sdcard_read_done = 1'b1;
          status_d.boot_done        = 1'b1;
        end
      end
      ST_UART_LOAD: begin
        if (mem_error) state_d = ST_HALT;
        else if (last_byte) begin
          state_d                 = ST_RUN;
          status_d.uart_load_done = 1'b1;
          status_d.boot_done      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    sd_prog_d   = sd_prog_q;
    uart_prog_d = uart_prog_q;
    if (in_sd)   sd_prog_d   = progress_next;
    if (in_uart) uart_prog_d = progress_next;
  end

  // Stage p0 -> registered state, pulses and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_WAIT_CALIB;
      status_q       <= '0;
      clear_start_q  <= 1'b0;
      sdcard_start_q <= 1'b0;
      sd_prog_q      <= '0;
      uart_prog_q    <= '0;
    end else begin
      state_q        <= state_d;
      status_q       <= status_d;
      clear_start_q  <= clear_start_d;
      sdcard_start_q <= sdcard_start_d;
      sd_prog_q      <= sd_prog_d;
      uart_prog_q    <= uart_prog_d;
    end
  end

  assign clear_start         = clear_start_q;
  assign sdcard_start        = sdcard_start_q;
  assign clear_screen_done   = status_q.clear_screen_done;
  assign sdcard_read_started = status_q.sdcard_read_started;
  assign sdcard_read_done    = status_q.sdcard_read_done;
  assign sdcard_read_error   = status_q.sdcard_read_error;
  assign uart_load_started   = status_q.uart_load_started;
  assign uart_load_done      = status_q.uart_load_done;
  assign boot_done           = status_q.boot_done;
  assign cpu_run             = status_q.boot_done;
  assign sdcard_progress     = sd_prog_q;
  assign uart_progress       = uart_prog_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench: dut_a runs the full 64 KiB SD boot, dut_b (256-byte load,
// 100-cycle SD timeout) covers UART, timeout, fail, mem_error and reset cases.
module tb_boot_sequencer;
  import boot_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mem_calib_done, mem_error, clear_done, sdcard_present;
  logic sdcard_byte_valid, sdcard_fail, uart_byte_valid;

  logic       a_clear_start, a_sdcard_start, a_clear_screen_done, a_sdcard_read_started;
  logic       a_sdcard_read_done, a_sdcard_read_error, a_uart_load_started;
  logic       a_uart_load_done, a_boot_done, a_cpu_run;
  logic [7:0] a_sdcard_progress, a_uart_progress;
  logic       b_clear_start, b_sdcard_start, b_clear_screen_done, b_sdcard_read_started;
  logic       b_sdcard_read_done, b_sdcard_read_error, b_uart_load_started;
  logic       b_uart_load_done, b_boot_done, b_cpu_run;
  logic [7:0] b_sdcard_progress, b_uart_progress;

  logic [25:0] a_all, b_all;
  assign a_all = {a_clear_start, a_sdcard_start, a_clear_screen_done, a_sdcard_read_started,
                  a_sdcard_read_done, a_sdcard_read_error, a_uart_load_started,
                  a_uart_load_done, a_boot_done, a_cpu_run, a_sdcard_progress, a_uart_progress};
  assign b_all = {b_clear_start, b_sdcard_start, b_clear_screen_done, b_sdcard_read_started,
                  b_sdcard_read_done, b_sdcard_read_error, b_uart_load_started,
                  b_uart_load_done, b_boot_done, b_cpu_run, b_sdcard_progress, b_uart_progress};

  boot_sequencer #(.LOAD_BYTES(65536), .SD_TIMEOUT(100)) dut_a (
    .clk(clk), .rst(rst), .mem_calib_done(mem_calib_done), .mem_error(mem_error),
    .clear_start(a_clear_start), .clear_done(clear_done), .sdcard_present(sdcard_present),
    .sdcard_start(a_sdcard_start), .sdcard_byte_valid(sdcard_byte_valid),
    .sdcard_fail(sdcard_fail), .uart_byte_valid(uart_byte_valid),
    .clear_screen_done(a_clear_screen_done), .sdcard_read_started(a_sdcard_read_started),
    .sdcard_read_done(a_sdcard_read_done), .sdcard_read_error(a_sdcard_read_error),
    .uart_load_started(a_uart_load_started), .uart_load_done(a_uart_load_done),
    .boot_done(a_boot_done), .sdcard_progress(a_sdcard_progress),
    .uart_progress(a_uart_progress), .cpu_run(a_cpu_run)
  );

  boot_sequencer #(.LOAD_BYTES(256), .SD_TIMEOUT(100)) dut_b (
    .clk(clk), .rst(rst), .mem_calib_done(mem_calib_done), .mem_error(mem_error),
    .clear_start(b_clear_start), .clear_done(clear_done), .sdcard_present(sdcard_present),
    .sdcard_start(b_sdcard_start), .sdcard_byte_valid(sdcard_byte_valid),
    .sdcard_fail(sdcard_fail), .uart_byte_valid(uart_byte_valid),
    .clear_screen_done(b_clear_screen_done), .sdcard_read_started(b_sdcard_read_started),
    .sdcard_read_done(b_sdcard_read_done), .sdcard_read_error(b_sdcard_read_error),
    .uart_load_started(b_uart_load_started), .uart_load_done(b_uart_load_done),
    .boot_done(b_boot_done), .sdcard_progress(b_sdcard_progress),
    .uart_progress(b_uart_progress), .cpu_run(b_cpu_run)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int a_cs_cnt = 0;
  int a_ss_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Pulse counters for dut_a, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      a_cs_cnt = 0;
      a_ss_cnt = 0;
    end else begin
      if (a_clear_start)  a_cs_cnt++;
      if (a_sdcard_start) a_ss_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_calib_done = 0; mem_error = 0; clear_done = 0; sdcard_present = 0;
    sdcard_byte_valid = 0; sdcard_fail = 0; uart_byte_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step(2);
    rst = 0;
  endtask

  task automatic enter_load(input logic present);
    mem_calib_done = 1;
    step(1);
    clear_done = 1;
    sdcard_present = present;
    step(1);
  endtask

  initial begin
    // Full SD boot on dut_a, reset values on both
    do_reset();
    check_eq("rst_a_outputs", a_all, 26'h0);
    check_eq("rst_b_outputs", b_all, 26'h0);
    check_eq("rst_state", dut_b.state_q, ST_WAIT_CALIB);
    step(10);
    mem_calib_done = 1;
    step(1);
    check_eq("a_clear_start", a_clear_start, 1);
    check_eq("a_state_clear", dut_a.state_q, ST_CLEAR);
    step(99);
    clear_done = 1;
    sdcard_present = 1;
    step(1);
    check_eq("a_sdcard_start", a_sdcard_start, 1);
    check_eq("a_clear_screen_done", a_clear_screen_done, 1);
    check_eq("a_sd_started", a_sdcard_read_started, 1);
    sdcard_byte_valid = 1;
    step(32768);
    check_eq("a_progress_half", a_sdcard_progress, 8'h80);
    step(32767);
    check_eq("a_boot_before_last", a_boot_done, 0);
    step(1);
    sdcard_byte_valid = 0;
    check_eq("a_boot_done", a_boot_done, 1);
    check_eq("a_cpu_run", a_cpu_run, 1);
    check_eq("a_sd_done", a_sdcard_read_done, 1);
    check_eq("a_progress_sat", a_sdcard_progress, 8'hFF);
    check_eq("a_clear_start_pulses", a_cs_cnt, 1);
    check_eq("a_sdcard_start_pulses", a_ss_cnt, 1);

    // UART load, card absent; stray SD bytes are ignored
    do_reset();
    enter_load(0);
    check_eq("b_uart_started", b_uart_load_started, 1);
    check_eq("b_no_sd_start", b_sdcard_start, 0);
    sdcard_byte_valid = 1;
    step(10);
    sdcard_byte_valid = 0;
    check_eq("b_inactive_ignored", dut_b.u_load_counter.count_q, 0);
    uart_byte_valid = 1;
    step(255);
    check_eq("b_uart_before_last", b_uart_load_done, 0);
    step(1);
    uart_byte_valid = 0;
    check_eq("b_uart_done", b_uart_load_done, 1);
    check_eq("b_uart_boot", b_boot_done, 1);
    check_eq("b_uart_sd_started", b_sdcard_read_started, 0);
    check_eq("b_uart_progress", b_uart_progress, 8'h01);

    // SD idle timeout
    do_reset();
    enter_load(1);
    check_eq("b_sd_start_pulse", b_sdcard_start, 1);
    sdcard_byte_valid = 1;
    step(3);
    sdcard_byte_valid = 0;
    check_eq("b_sd_start_low", b_sdcard_start, 0);
    step(99);
    check_eq("b_err_at_99", b_sdcard_read_error, 0);
    check_eq("b_state_at_99", dut_b.state_q, ST_SD_LOAD);
    step(1);
    check_eq("b_err_at_100", b_sdcard_read_error, 1);
    check_eq("b_timeout_boot", b_boot_done, 0);
    check_eq("b_timeout_halt", dut_b.state_q, ST_HALT);

    // sdcard_fail coincident with byte 5
    do_reset();
    enter_load(1);
    sdcard_byte_valid = 1;
    step(4);
    sdcard_fail = 1;
    step(1);
    sdcard_byte_valid = 0;
    sdcard_fail = 0;
    check_eq("b_fail_count", dut_b.u_load_counter.count_q, 4);
    check_eq("b_fail_halt", dut_b.state_q, ST_HALT);
    check_eq("b_fail_error", b_sdcard_read_error, 1);

    // mem_error in CLEAR halts; in RUN it is ignored
    do_reset();
    mem_calib_done = 1;
    step(1);
    mem_error = 1;
    step(1);
    mem_error = 0;
    check_eq("b_memerr_halt", dut_b.state_q, ST_HALT);
    clear_done = 1;
    sdcard_present = 1;
    step(2);
    check_eq("b_halt_sticky", dut_b.state_q, ST_HALT);
    check_eq("b_halt_no_clear_done", b_clear_screen_done, 0);
    check_eq("b_halt_no_sd_start", b_sdcard_start, 0);
    do_reset();
    enter_load(0);
    uart_byte_valid = 1;
    step(256);
    uart_byte_valid = 0;
    check_eq("b_run_before_err", b_cpu_run, 1);
    mem_error = 1;
    step(1);
    mem_error = 0;
    step(1);
    check_eq("b_run_after_err", b_cpu_run, 1);
    check_eq("b_run_state", dut_b.state_q, ST_RUN);

    // Reset mid SD load, then clean restart
    do_reset();
    enter_load(1);
    sdcard_byte_valid = 1;
    step(50);
    check_eq("b_mid_count", dut_b.u_load_counter.count_q, 50);
    rst = 1;
    step(1);
    idle_inputs();
    check_eq("b_midrst_outputs", b_all, 26'h0);
    check_eq("b_midrst_state", dut_b.state_q, ST_WAIT_CALIB);
    check_eq("b_midrst_count", dut_b.u_load_counter.count_q, 0);
    rst = 0;
    step(5);
    check_eq("b_no_restart_pulse", b_sdcard_start, 0);
    mem_calib_done = 1;
    step(1);
    check_eq("b_restart_clear_start", b_clear_start, 1);
    clear_done = 1;
    sdcard_present = 1;
    step(1);
    check_eq("b_restart_sd_start", b_sdcard_start, 1);
    sdcard_byte_valid = 1;
    step(256);
    sdcard_byte_valid = 0;
    check_eq("b_restart_boot", b_boot_done, 1);
    check_eq("b_restart_progress", b_sdcard_progress, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
